// File: rtl/cpu_defs.sv
// Shared pipeline definitions: hazard FSM encoding, destination-tag layout,
// multiply/divide latency defaults and the segment control bundle.
package cpu_defs;

  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] RUN      = 2'd0;
  localparam logic [STATE_W-1:0] MEM_WAIT = 2'd1;
  localparam logic [STATE_W-1:0] DRAIN    = 2'd2;

  // Bit of the 6-bit destination tag marking a non-GPR (HI/LO/CP0) target.
  localparam int unsigned WREG_NONGPR = 5;
  localparam int unsigned WREG_W      = 6;
  localparam int unsigned REG_W       = 5;

  localparam int unsigned MUL_CYCLES_DEF = 2;
  localparam int unsigned DIV_CYCLES_DEF = 33;
  localparam int unsigned MD_CNT_W       = 6;

  // Per-segment hold/bubble controls.
  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic flush_id;
    logic flush_ex;
    logic flush_mem;
    logic flush_wb;
  } pipe_ctl_t;

  // Busy-counter preload: the issue cycle itself is not counted as busy.
  function automatic logic [MD_CNT_W-1:0] md_load_val(input logic        is_div,
                                                      input int unsigned mul_c,
                                                      input int unsigned div_c);
    return is_div ? MD_CNT_W'(div_c - 1) : MD_CNT_W'(mul_c - 1);
  endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Multiply/divide busy counter: clear has priority over load, otherwise
// counts down to zero. busy_o is high while the HI/LO result is pending.
module md_busy_cnt
  import cpu_defs::*;
#(
  parameter int unsigned W = MD_CNT_W
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         busy_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, preload, or decrement while nonzero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline. Resolves
// exception, data-bus wait, HI/LO and load-use hazards in fixed priority
// and drives hold/bubble controls for every segment register.
module pipe_hazard_ctrl
  import cpu_defs::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_rs_ren,
  input  logic              id_rt_ren,
  input  logic              ex_load,
  input  logic              ex_cp0ren,
  input  logic              ex_regwen,
  input  logic [WREG_W-1:0] ex_wreg,
  input  logic              ex_md_start,
  input  logic              ex_md_div,
  input  logic [1:0]        ex_hiloren,
  input  logic              mem_data_en,
  input  logic              mem_data_ok,
  input  logic              wb_exc,
  input  logic              wb_eret,
  output logic              stall_if,
  output logic              stall_id,
  output logic              stall_ex,
  output logic              stall_mem,
  output logic              flush_id,
  output logic              flush_ex,
  output logic              flush_mem,
  output logic              flush_wb,
  output logic              md_busy
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  pipe_ctl_t          ctl;
  logic               md_busy_raw;
  logic               md_clr;
  logic               md_load;
  logic               exc;
  logic               lu;
  logic               mdh;
  logic               mw;
  logic               mem_hold;
  logic               gpr_dst;

  // Hazard detection from same-cycle pipeline inputs.
  always_comb begin
    exc      = wb_exc | wb_eret;
    gpr_dst  = ex_regwen & ~ex_wreg[WREG_NONGPR] & (ex_wreg[REG_W-1:0] != '0);
    lu       = (ex_load | ex_cp0ren) & gpr_dst &
               ((id_rs_ren & (ex_wreg[REG_W-1:0] == id_rs)) |
                (id_rt_ren & (ex_wreg[REG_W-1:0] == id_rt)));
    mdh      = md_busy_raw & ((ex_hiloren != 2'b00) | ex_md_start);
    mw       = mem_data_en & ~mem_data_ok;
    mem_hold = mw | ((state_q == MEM_WAIT) & ~mem_data_ok);
  end

  // Priority mux and next-state logic.
  always_comb begin
    state_d = RUN;
    ctl     = '0;
    md_clr  = 1'b0;
    if (exc) begin
      ctl.flush_id  = 1'b1;
      ctl.flush_ex  = 1'b1;
      ctl.flush_mem = 1'b1;
      ctl.flush_wb  = 1'b1;
      md_clr        = 1'b1;
      if (mw || (((state_q == MEM_WAIT) || (state_q == DRAIN)) && !mem_data_ok)) begin
        state_d = DRAIN;
      end
    end else if (state_q == DRAIN) begin
      ctl.flush_id  = 1'b1;
      ctl.flush_ex  = 1'b1;
      ctl.flush_mem = 1'b1;
      ctl.flush_wb  = 1'b1;
      ctl.stall_if  = 1'b1;
      state_d       = mem_data_ok ? RUN : DRAIN;
    end else if (mem_hold) begin
      ctl.stall_if  = 1'b1;
      ctl.stall_id  = 1'b1;
      ctl.stall_ex  = 1'b1;
      ctl.stall_mem = 1'b1;
      ctl.flush_wb  = 1'b1;
      state_d       = MEM_WAIT;
    end else if (mdh) begin
      ctl.stall_if  = 1'b1;
      ctl.stall_id  = 1'b1;
      ctl.stall_ex  = 1'b1;
      ctl.flush_mem = 1'b1;
    end else if (lu) begin
      ctl.stall_if  = 1'b1;
      ctl.stall_id  = 1'b1;
      ctl.flush_ex  = 1'b1;
    end
  end

  // A new mult/div only starts when idle and not blocked by a higher source.
  assign md_load = ex_md_start & ~md_busy_raw & ~exc & (state_q != DRAIN) & ~mem_hold;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  md_busy_cnt #(
    .W (MD_CNT_W)
  ) u_md_busy_cnt (
    .clk        (clk),
    .resetn     (resetn),
    .clr_i      (md_clr),
    .load_i     (md_load),
    .load_val_i (md_load_val(ex_md_div, MUL_CYCLES, DIV_CYCLES)),
    .busy_o     (md_busy_raw)
  );

  // Outputs are held low for the whole reset window.
  assign stall_if  = resetn & ctl.stall_if;
  assign stall_id  = resetn & ctl.stall_id;
  assign stall_ex  = resetn & ctl.stall_ex;
  assign stall_mem = resetn & ctl.stall_mem;
  assign flush_id  = resetn & ctl.flush_id;
  assign flush_ex  = resetn & ctl.flush_ex;
  assign flush_mem = resetn & ctl.flush_mem;
  assign flush_wb  = resetn & ctl.flush_wb;
  assign md_busy   = resetn & md_busy_raw;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed test-plan sequences
// followed by random traffic, checked against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MULC = 2;
  localparam int unsigned DIVC = 33;

  typedef struct packed {
    logic       resetn;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_rs_ren;
    logic       id_rt_ren;
    logic       ex_load;
    logic       ex_cp0ren;
    logic       ex_regwen;
    logic [5:0] ex_wreg;
    logic       ex_md_start;
    logic       ex_md_div;
    logic [1:0] ex_hiloren;
    logic       mem_data_en;
    logic       mem_data_ok;
    logic       wb_exc;
    logic       wb_eret;
  } stim_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  stim_t cur;
  stim_t idle;

  logic stall_if, stall_id, stall_ex, stall_mem;
  logic flush_id, flush_ex, flush_mem, flush_wb, md_busy;

  pipe_hazard_ctrl #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk         (clk),
    .resetn      (cur.resetn),
    .id_rs       (cur.id_rs),
    .id_rt       (cur.id_rt),
    .id_rs_ren   (cur.id_rs_ren),
    .id_rt_ren   (cur.id_rt_ren),
    .ex_load     (cur.ex_load),
    .ex_cp0ren   (cur.ex_cp0ren),
    .ex_regwen   (cur.ex_regwen),
    .ex_wreg     (cur.ex_wreg),
    .ex_md_start (cur.ex_md_start),
    .ex_md_div   (cur.ex_md_div),
    .ex_hiloren  (cur.ex_hiloren),
    .mem_data_en (cur.mem_data_en),
    .mem_data_ok (cur.mem_data_ok),
    .wb_exc      (cur.wb_exc),
    .wb_eret     (cur.wb_eret),
    .stall_if    (stall_if),
    .stall_id    (stall_id),
    .stall_ex    (stall_ex),
    .stall_mem   (stall_mem),
    .flush_id    (flush_id),
    .flush_ex    (flush_ex),
    .flush_mem   (flush_mem),
    .flush_wb    (flush_wb),
    .md_busy     (md_busy)
  );

  // Reference model state: remaining busy cycles, waiting on data bus, draining.
  int  m_busy  = 0;
  bit  m_wait  = 0;
  bit  m_drain = 0;
  int  cyc     = 0;
  int  total   = 0;
  int  bad     = 0;
  logic [8:0] expq[$];

  // Apply one cycle of stimulus, push the expected outputs, advance the model.
  task automatic step(input stim_t s);
    logic [8:0] e;
    bit exc, lu, busy, mw, hold, blocked;
    int nb;
    @(posedge clk);
    #1;
    cur = s;
    cyc++;
    e = '0;
    if (!s.resetn) begin
      m_busy = 0; m_wait = 0; m_drain = 0;
    end else begin
      exc  = s.wb_exc || s.wb_eret;
      busy = (m_busy > 0);
      mw   = s.mem_data_en && !s.mem_data_ok;
      hold = mw || (m_wait && !s.mem_data_ok);
      lu   = (s.ex_load || s.ex_cp0ren) && s.ex_regwen &&
             (s.ex_wreg >= 6'd1) && (s.ex_wreg <= 6'd31) &&
             ((s.id_rs_ren && s.id_rs == s.ex_wreg[4:0]) ||
              (s.id_rt_ren && s.id_rt == s.ex_wreg[4:0]));
      blocked = exc || m_drain || hold;
      if (exc) nb = 0;
      else if (s.ex_md_start && !busy && !blocked) nb = s.ex_md_div ? int'(DIVC) - 1 : int'(MULC) - 1;
      else nb = busy ? m_busy - 1 : 0;

      if (exc) begin
        e[4:1]  = 4'hF;
        m_drain = mw || ((m_wait || m_drain) && !s.mem_data_ok);
        m_wait  = 0;
      end else if (m_drain) begin
        e[4:1]  = 4'hF;
        e[8]    = 1'b1;
        m_drain = !s.mem_data_ok;
      end else if (hold) begin
        e[8:5]  = 4'hF;
        e[1]    = 1'b1;
        m_wait  = 1;
      end else begin
        m_wait = 0;
        if (busy && (s.ex_hiloren != 2'b00 || s.ex_md_start)) begin
          e[8:6] = 3'b111;
          e[2]   = 1'b1;
        end else if (lu) begin
          e[8:7] = 2'b11;
          e[3]   = 1'b1;
        end
      end
      e[0]   = busy;
      m_busy = nb;
    end
    expq.push_back(e);
  endtask

  function automatic stim_t rnd();
    stim_t s;
    s = idle;
    s.resetn      = ($urandom_range(0, 199) != 0);
    s.id_rs       = 5'($urandom_range(0, 3));
    s.id_rt       = 5'($urandom_range(0, 3));
    s.id_rs_ren   = 1'($urandom_range(0, 1));
    s.id_rt_ren   = 1'($urandom_range(0, 1));
    s.ex_load     = ($urandom_range(0, 2) == 0);
    s.ex_cp0ren   = ($urandom_range(0, 7) == 0);
    s.ex_regwen   = ($urandom_range(0, 3) != 0);
    case ($urandom_range(0, 3))
      0:       s.ex_wreg = 6'd0;
      3:       s.ex_wreg = 6'(32 + $urandom_range(0, 3));
      default: s.ex_wreg = 6'($urandom_range(1, 3));
    endcase
    s.ex_md_start = ($urandom_range(0, 9) == 0);
    s.ex_md_div   = ($urandom_range(0, 3) == 0);
    s.ex_hiloren  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    s.mem_data_en = ($urandom_range(0, 2) == 0);
    s.mem_data_ok = 1'($urandom_range(0, 1));
    s.wb_exc      = ($urandom_range(0, 39) == 0);
    s.wb_eret     = ($urandom_range(0, 59) == 0);
    return s;
  endfunction

  // Monitor: compare DUT outputs against the queued expectation mid-cycle.
  always @(negedge clk) begin
    logic [8:0] got;
    logic [8:0] exp_v;
    if (expq.size() > 0) begin
      exp_v = expq.pop_front();
      got = {stall_if, stall_id, stall_ex, stall_mem,
             flush_id, flush_ex, flush_mem, flush_wb, md_busy};
      total++;
      if (got !== exp_v) begin
        bad++;
        $display("FAIL ctl_outputs cyc=%0d got=%b exp=%b (sif,sid,sex,smem,fid,fex,fmem,fwb,busy)",
                 cyc, got, exp_v);
      end
    end
  end

  initial begin
    stim_t s;
    idle = '0;
    idle.resetn = 1'b1;
    cur = '0;

    // Reset
    s = idle; s.resetn = 1'b0;
    repeat (3) step(s);
    repeat (2) step(idle);

    // Load-use: real hazard, then r0 and non-GPR targets
    s = idle; s.ex_load = 1; s.ex_regwen = 1; s.ex_wreg = 6'd8; s.id_rs = 5'd8; s.id_rs_ren = 1;
    step(s); step(idle);
    s.ex_wreg = 6'd0; step(s);
    s.ex_wreg = 6'h28; s.id_rs = 5'd8; step(s);
    s = idle; s.ex_cp0ren = 1; s.ex_regwen = 1; s.ex_wreg = 6'd31; s.id_rt = 5'd31; s.id_rt_ren = 1;
    step(s); step(idle);

    // Divide then dependent mfhi held until release
    s = idle; s.ex_md_start = 1; s.ex_md_div = 1; step(s);
    s = idle; s.ex_hiloren = 2'b10; repeat (34) step(s);
    // Multiply then dependent mflo
    s = idle; s.ex_md_start = 1; step(s);
    s = idle; s.ex_hiloren = 2'b01; repeat (3) step(s);

    // Memory wait of three cycles
    s = idle; s.mem_data_en = 1; repeat (3) step(s);
    s.mem_data_ok = 1; step(s);
    step(idle);
    // Same-cycle data_ok: no stall
    step(s); step(idle);

    // Exception mid-wait with divide running
    s = idle; s.ex_md_start = 1; s.ex_md_div = 1; step(s);
    s = idle; s.mem_data_en = 1; repeat (2) step(s);
    s.wb_exc = 1; step(s);
    s = idle; repeat (3) step(s);
    s.mem_data_ok = 1; step(s);
    s = idle; s.ex_hiloren = 2'b11; repeat (2) step(s);

    // Priority collision: LU + MDH + MW, then with eret
    s = idle; s.ex_md_start = 1; s.ex_md_div = 1; step(s);
    s = idle; s.ex_load = 1; s.ex_regwen = 1; s.ex_wreg = 6'd5; s.id_rs = 5'd5; s.id_rs_ren = 1;
    s.ex_hiloren = 2'b10; s.mem_data_en = 1;
    repeat (2) step(s);
    s.wb_eret = 1; step(s);
    s.wb_eret = 0; s.mem_data_ok = 1; step(s);
    repeat (2) step(idle);

    // Reset mid-divide at count 20
    s = idle; s.ex_md_start = 1; s.ex_md_div = 1; step(s);
    repeat (12) step(idle);
    s = idle; s.resetn = 1'b0; s.ex_hiloren = 2'b10; s.mem_data_en = 1; s.wb_exc = 1;
    repeat (2) step(s);
    s = idle; s.ex_hiloren = 2'b10; repeat (3) step(s);

    // Random traffic
    repeat (4000) step(rnd());
    step(idle);

    for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (expq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_queue pending=%0d required=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
